// File: rtl/fifo_syn_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
// Holds the read-mode selectors and an elaboration-time log2 helper.
package fifo_syn_pkg;

   localparam int unsigned FWFT_OFF = 32'd0;
   localparam int unsigned FWFT_ON  = 32'd1;

   // Smallest n such that 2^n >= value.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 32'd0;
      while ((64'd1 << result) < 64'(value)) begin
         result = result + 32'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_syn_dual_port_ram.sv
// Storage array for fifo_syn: one clocked write port and an asynchronous read port.
// Contents are intentionally never reset.
module dual_port_ram
   import fifo_syn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  w_en,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   output logic [DATA_WIDTH-1:0] r_data
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (w_en) begin
         mem_q[w_addr] <= w_data;
      end
   end

   assign r_data = mem_q[r_addr];

endmodule

// File: rtl/fifo_syn.sv
// Single-clock FIFO with level flags, sticky error flags and selectable
// standard or first-word-fall-through read behaviour.
module fifo_syn
   import fifo_syn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDR_WIDTH    = 3,
   parameter int unsigned AFULL_THRESH  = (32'd1 << ADDR_WIDTH) - 32'd2,
   parameter int unsigned AEMPTY_THRESH = 1,
   parameter int unsigned FWFT          = FWFT_OFF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  r_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
   localparam int unsigned PTR_W = clog2(DEPTH) + 32'd1;

   localparam logic [PTR_W-1:0] DEPTH_LVL  = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] AFULL_LVL  = PTR_W'(AFULL_THRESH);
   localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_THRESH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             afull_q, afull_d;
   logic             aempty_q, aempty_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic                  wa_c;
   logic                  ra_c;
   logic                  ram_we_c;
   logic [DATA_WIDTH-1:0] ram_rd_data;

   // Acceptance: a pop frees a slot, so a write to a full FIFO still lands
   // when paired with a read.
   always_comb begin
      ra_c     = r_en & ~empty_q;
      wa_c     = w_en & (~full_q | ra_c);
      ram_we_c = wa_c & ~clr;
   end

   // Pointer, occupancy and sticky-flag update; flush beats any request.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (clr) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wa_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (ra_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         unique case ({wa_c, ra_c})
            2'b10:   count_d = count_q + PTR_W'(1);
            2'b01:   count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
         endcase
         overflow_d  = overflow_q  | (w_en & ~wa_c);
         underflow_d = underflow_q | (r_en & empty_q);
      end
   end

   // Flags are registered alongside count so they always agree with it.
   always_comb begin
      full_d   = (count_d == DEPTH_LVL);
      empty_d  = (count_d == '0);
      afull_d  = (count_d >= AFULL_LVL);
      aempty_d = (count_d <= AEMPTY_LVL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         afull_q     <= afull_d;
         aempty_q    <= aempty_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   dual_port_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk    (clk),
      .w_en   (ram_we_c),
      .w_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
      .w_data (w_data),
      .r_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
      .r_data (ram_rd_data)
   );

   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   generate
      if (FWFT == FWFT_ON) begin : g_fwft
         // Head word is always presented; a read simply advances past it.
         assign r_data  = ram_rd_data;
         assign r_valid = ~empty_q;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
         logic                  r_valid_q, r_valid_d;

         always_comb begin
            r_data_d  = r_data_q;
            r_valid_d = 1'b0;
            if (!clr && ra_c) begin
               r_data_d  = ram_rd_data;
               r_valid_d = 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               r_data_q  <= '0;
               r_valid_q <= 1'b0;
            end else begin
               r_data_q  <= r_data_d;
               r_valid_q <= r_valid_d;
            end
         end

         assign r_data  = r_data_q;
         assign r_valid = r_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_syn.sv
// Bench for fifo_syn: a default standard-read instance and a 32x32 FWFT instance
// share one stimulus stream and are compared against queue-based reference models.
module tb_fifo_syn;

   logic        clk;
   logic        rst;
   logic        clr;
   logic        w_en;
   logic        r_en;
   logic [31:0] w_data;

   logic [7:0]  r_data0;
   logic        r_valid0, full0, empty0, afull0, aempty0, ovf0, unf0;
   logic [3:0]  count0;

   logic [31:0] r_data1;
   logic        r_valid1, full1, empty1, afull1, aempty1, ovf1, unf1;
   logic [5:0]  count1;

   int total;
   int bad;

   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic        ovf_m [2];
   logic        unf_m [2];
   logic [7:0]  rd_m;
   logic        rv_m;

   fifo_syn dut0 (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .w_en         (w_en),
      .w_data       (w_data[7:0]),
      .r_en         (r_en),
      .r_data       (r_data0),
      .r_valid      (r_valid0),
      .full         (full0),
      .empty        (empty0),
      .almost_full  (afull0),
      .almost_empty (aempty0),
      .count        (count0),
      .overflow     (ovf0),
      .underflow    (unf0)
   );

   fifo_syn #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (5),
      .FWFT       (1)
   ) dut1 (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .w_en         (w_en),
      .w_data       (w_data),
      .r_en         (r_en),
      .r_data       (r_data1),
      .r_valid      (r_valid1),
      .full         (full1),
      .empty        (empty1),
      .almost_full  (afull1),
      .almost_empty (aempty1),
      .count        (count1),
      .overflow     (ovf1),
      .underflow    (unf1)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int qsize(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   task automatic qclear(input int k);
      if (k == 0) q0.delete(); else q1.delete();
   endtask

   task automatic qpush(input int k, input logic [31:0] v);
      if (k == 0) q0.push_back(v); else q1.push_back(v);
   endtask

   task automatic qpop(input int k, output logic [31:0] v);
      if (k == 0) v = q0.pop_front(); else v = q1.pop_front();
   endtask

   // Reference behaviour: a FIFO of words with explicit accept rules.
   task automatic model_step(input logic rs, input logic cl, input logic we,
                             input logic re, input logic [31:0] wd);
      for (int k = 0; k < 2; k++) begin
         int          depth;
         int          sz;
         logic        was_empty;
         logic        was_full;
         logic        rd_ok;
         logic        wr_ok;
         logic [31:0] v;
         depth = (k == 0) ? 8 : 32;
         sz    = qsize(k);
         if (rs || cl) begin
            qclear(k);
            ovf_m[k] = 1'b0;
            unf_m[k] = 1'b0;
            if (k == 0) begin
               rv_m = 1'b0;
               if (rs) rd_m = 8'h00;
            end
         end else begin
            was_empty = (sz == 0);
            was_full  = (sz == depth);
            rd_ok     = re && !was_empty;
            wr_ok     = we && (!was_full || rd_ok);
            if (k == 0) rv_m = rd_ok;
            if (rd_ok) begin
               qpop(k, v);
               if (k == 0) rd_m = v[7:0];
            end
            if (wr_ok) qpush(k, (k == 0) ? {24'd0, wd[7:0]} : wd);
            if (we && !wr_ok) ovf_m[k] = 1'b1;
            if (re && was_empty) unf_m[k] = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      int s0;
      int s1;
      s0 = q0.size();
      s1 = q1.size();
      check_val("d0.count",   32'(count0),   32'(s0));
      check_val("d0.full",    32'(full0),    32'(s0 == 8));
      check_val("d0.empty",   32'(empty0),   32'(s0 == 0));
      check_val("d0.afull",   32'(afull0),   32'(s0 >= 6));
      check_val("d0.aempty",  32'(aempty0),  32'(s0 <= 1));
      check_val("d0.ovf",     32'(ovf0),     32'(ovf_m[0]));
      check_val("d0.unf",     32'(unf0),     32'(unf_m[0]));
      check_val("d0.r_valid", 32'(r_valid0), 32'(rv_m));
      check_val("d0.r_data",  32'(r_data0),  32'(rd_m));
      check_val("d1.count",   32'(count1),   32'(s1));
      check_val("d1.full",    32'(full1),    32'(s1 == 32));
      check_val("d1.empty",   32'(empty1),   32'(s1 == 0));
      check_val("d1.afull",   32'(afull1),   32'(s1 >= 30));
      check_val("d1.aempty",  32'(aempty1),  32'(s1 <= 1));
      check_val("d1.ovf",     32'(ovf1),     32'(ovf_m[1]));
      check_val("d1.unf",     32'(unf1),     32'(unf_m[1]));
      check_val("d1.r_valid", 32'(r_valid1), 32'(s1 != 0));
      if (s1 != 0) check_val("d1.r_data", r_data1, q1[0]);
   endtask

   task automatic cycle(input logic rs, input logic cl, input logic we,
                        input logic re, input logic [31:0] wd);
      @(negedge clk);
      rst    = rs;
      clr    = cl;
      w_en   = we;
      r_en   = re;
      w_data = wd;
      @(posedge clk);
      model_step(rs, cl, we, re, wd);
      #1;
      check_all();
   endtask

   initial begin
      int wprob;
      int rprob;
      clk    = 1'b0;
      rst    = 1'b1;
      clr    = 1'b0;
      w_en   = 1'b0;
      r_en   = 1'b0;
      w_data = '0;
      total  = 0;
      bad    = 0;
      rd_m   = 8'h00;
      rv_m   = 1'b0;

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      // Fill past full, then a paired write/read at full.
      for (int i = 1; i <= 9; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'(i));
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hAA);

      // Drain everything and one more to provoke underflow.
      for (int i = 0; i < 11; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

      // Flush with five resident and a concurrent write.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h10 + 32'(i));
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h77);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h33);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h34);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

      // Reset mid-operation with a concurrent write.
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h20 + 32'(i));
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h99);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h42);
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

      // Single word into an empty FIFO, idle, then pop.
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h5C);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

      // Pointer wrap with three words resident.
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hC0 + 32'(i));
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, $urandom);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

      // Random traffic with alternating fill/drain bias and rare flush/reset.
      for (int i = 0; i < 2400; i++) begin
         if (((i / 150) % 2) == 0) begin
            wprob = 75;
            rprob = 35;
         end else begin
            wprob = 30;
            rprob = 75;
         end
         cycle(1'($urandom_range(0, 299) == 0),
               1'($urandom_range(0, 199) == 0),
               1'($urandom_range(0, 99) < wprob),
               1'($urandom_range(0, 99) < rprob),
               $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
